// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and request legality helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        if (store) begin
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        end
        return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction

    // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/half lane handling: load extract with sign/zero extension, and sub-word store merge.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = word[{offset[1], 4'b0000} +: 16];

        load_val = word;
        case (funct3)
            F3_B:    load_val = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_BU:   load_val = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_H:    load_val = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_HU:   load_val = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_val = word;
        endcase

        // Sub-word stores keep the surrounding bytes of the word just read
        merged = wdata;
        case (funct3)
            F3_B: begin
                merged = word;
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                merged = word;
                merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns CPU load/store requests into word accesses, with RMW for SB/SH.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 18,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_store,
    input  logic [2:0]               req_funct3,
    input  logic [DATA_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_wen,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    lsu_state_e state_q, state_d;

    logic                     store_q, store_d;
    logic [2:0]               f3_q, f3_d;
    logic [1:0]               off_q, off_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     ready_d;
    logic                     rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_d;
    logic                     rsp_err_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_d;
    logic                     mem_wen_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_d;

    logic [DATA_WIDTH-1:0]    load_val;
    logic [DATA_WIDTH-1:0]    merged;

    // Address bits above the memory range wrap away
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[DATA_WIDTH-1:ADDRESS_WIDTH+2];

    lsu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .word     (mem_rdata),
        .offset   (off_q),
        .funct3   (f3_q),
        .wdata    (wdata_q),
        .load_val (load_val),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            store_q   <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            store_q   <= store_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            wdata_q   <= wdata_d;
            req_ready <= ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            mem_addr  <= mem_addr_d;
            mem_wen   <= mem_wen_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Next state plus next value of every registered output
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        f3_d        = f3_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wen_d   = 1'b0;
        mem_wdata_d = mem_wdata;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    store_d    = req_store;
                    f3_d       = req_funct3;
                    off_d      = req_addr[1:0];
                    wdata_d    = req_wdata;
                    mem_addr_d = req_addr[ADDRESS_WIDTH+1:2];
                    if (f3_illegal(req_store, req_funct3) || misaligned(req_funct3, req_addr[1:0])) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_store && req_funct3 == F3_W) begin
                        state_d     = WRITE;
                        mem_wen_d   = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (store_q) begin
                    state_d     = WRITE;
                    mem_wen_d   = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_val;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized traffic against a reference model.
module tb_load_store_unit;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [2:0]    req_funct3;
    logic [DW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [int];

    int errors = 0;
    int checks = 0;

    load_store_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wdata;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input int wi);
        return ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
    endfunction

    // Reference behaviour from the access rules: size, alignment, extension, lane merge
    function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output bit err, output logic [31:0] rd,
                                  output logic [31:0] neww, output int lat, output bit wr);
        int wi, off, sz;
        logic [31:0] w, mask;
        bit legal;
        wi    = int'((addr >> 2) % (32'd1 << AW));
        off   = int'(addr % 4);
        w     = ref_rd(wi);
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz    = 1 << (f3 % 4);
        err   = !legal || (off % sz != 0);
        rd    = 32'h0;
        neww  = w;
        wr    = 1'b0;
        if (err) begin
            lat = 1;
        end else if (!st) begin
            lat = 2;
            if (sz == 4) rd = w;
            else begin
                mask = (32'd1 << (8 * sz)) - 1;
                rd   = (w >> (8 * off)) & mask;
                if (f3 < 4 && rd[8*sz-1]) rd = rd | ~mask;
            end
        end else begin
            wr  = 1'b1;
            lat = (sz == 4) ? 2 : 3;
            if (sz == 4) neww = wd;
            else begin
                mask = ((32'd1 << (8 * sz)) - 1) << (8 * off);
                neww = (w & ~mask) | ((wd << (8 * off)) & mask);
            end
        end
    endfunction

    // One full transaction from a falling edge; returns at the falling edge of the response cycle
    task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input string tag);
        bit err_e, wr_e, got;
        logic [31:0] rd_e, new_e, obs_rd;
        logic obs_err;
        int lat_e, lat, wens, wi, waits;
        model(st, f3, addr, wd, err_e, rd_e, new_e, lat_e, wr_e);
        wi = int'((addr >> 2) % (32'd1 << AW));
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        waits = 0;
        while (!req_ready && waits < 10) begin @(negedge clk); waits++; end
        if (!req_ready) check({tag, "/accept"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 1'b0; lat = 0; wens = 0; obs_rd = 32'h0; obs_err = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (c == 1 && !err_e) check({tag, "/mem_addr"}, 32'(mem_addr), 32'(wi));
            if (mem_wen) wens++;
            if (rsp_valid) begin got = 1'b1; lat = c; obs_rd = rsp_rdata; obs_err = rsp_err; end
        end
        if (wr_e) ref_mem[wi] = new_e;
        check({tag, "/latency"}, 32'(lat), 32'(lat_e));
        check({tag, "/rdata"}, obs_rd, rd_e);
        check({tag, "/err"}, 32'(obs_err), 32'(err_e));
        check({tag, "/wen_cycles"}, 32'(wens), wr_e ? 32'd1 : 32'd0);
        check({tag, "/mem_word"}, mem[wi], ref_rd(wi));
    endtask

    initial begin
        int vcount, wcount;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899AABB;
        ref_mem[4] = 32'h8899AABB;

        repeat (2) @(negedge clk);
        check("rst/req_ready", 32'(req_ready), 32'd1);
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/rsp_rdata", rsp_rdata, 32'd0);
        check("rst/rsp_err", 32'(rsp_err), 32'd0);
        check("rst/mem_wen", 32'(mem_wen), 32'd0);
        check("rst/mem_wdata", mem_wdata, 32'd0);
        check("rst/mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b0, 3'b000, 32'h13, 32'h0, "LB_13");
        check("LB_13/value", rsp_rdata, 32'hFFFFFF88);
        txn(1'b0, 3'b100, 32'h12, 32'h0, "LBU_12");
        check("LBU_12/value", rsp_rdata, 32'h00000099);
        txn(1'b0, 3'b001, 32'h12, 32'h0, "LH_12");
        check("LH_12/value", rsp_rdata, 32'hFFFF8899);
        txn(1'b0, 3'b101, 32'h10, 32'h0, "LHU_10");
        check("LHU_10/value", rsp_rdata, 32'h0000AABB);
        txn(1'b0, 3'b010, 32'h10, 32'h0, "LW_10");
        check("LW_10/value", rsp_rdata, 32'h8899AABB);
        txn(1'b1, 3'b000, 32'h11, 32'h000000CC, "SB_11");
        check("SB_11/word", mem[4], 32'h8899CCBB);
        txn(1'b1, 3'b001, 32'h12, 32'h00001234, "SH_12");
        check("SH_12/word", mem[4], 32'h1234CCBB);
        txn(1'b0, 3'b010, 32'h11, 32'h0, "LW_11_misaligned");
        txn(1'b1, 3'b001, 32'h13, 32'h5555, "SH_13_misaligned");
        txn(1'b0, 3'b011, 32'h10, 32'h0, "LOAD_F3_011");
        txn(1'b1, 3'b100, 32'h10, 32'h0, "STORE_F3_100");
        txn(1'b0, 3'b010, 32'h01000010, 32'h0, "LW_wrap");
        check("LW_wrap/value", rsp_rdata, 32'h1234CCBB);

        // Reset pulsed while an SB sits in READ: nothing may be written or answered
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'hEE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort/mem_wen_async", 32'(mem_wen), 32'd0);
        check("abort/req_ready_async", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0; wcount = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) vcount++;
            if (mem_wen) wcount++;
        end
        check("abort/rsp_valid_cycles", 32'(vcount), 32'd0);
        check("abort/wen_cycles", 32'(wcount), 32'd0);
        check("abort/word4", mem[4], ref_rd(4));
        check("abort/req_ready", 32'(req_ready), 32'd1);

        // SW then LW with req_valid held: second accept lands the cycle after RESP
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_store = 1'b0; req_addr = 32'h20; req_wdata = 32'h0;
        ref_mem[8] = 32'hDEADBEEF;
        @(negedge clk);
        check("b2b/sw_wen", 32'(mem_wen), 32'd1);
        check("b2b/sw_ready_busy", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("b2b/sw_rsp_valid", 32'(rsp_valid), 32'd1);
        check("b2b/sw_rsp_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("b2b/idle_ready", 32'(req_ready), 32'd1);
        check("b2b/word8", mem[8], 32'hDEADBEEF);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b/lw_accepted", 32'(req_ready), 32'd0);
        check("b2b/lw_mem_addr", 32'(mem_addr), 32'd8);
        @(negedge clk);
        check("b2b/lw_rsp_valid", 32'(rsp_valid), 32'd1);
        check("b2b/lw_rdata", rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Randomized traffic over words 0..7 with junk in the wrapped upper address bits
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFF0_001F);
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                $sformatf("rnd%0d", n));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
